// File: rtl/key_pkg.sv
// Shared definitions for the key input path: FSM state encoding and the
// 25 MHz default timing constants also used by the per-key debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE    = 2'd0,
        KEY_PRESSED = 2'd1,
        KEY_LONG    = 2'd2
    } key_state_e;

    localparam int unsigned KEY_CNT_W = 25;

    // 1 s hold and 200 ms repeat period at the nominal 25 MHz clock
    localparam logic [KEY_CNT_W-1:0] KEY_LONG_CNT_25M   = 25'd25000000;
    localparam logic [KEY_CNT_W-1:0] KEY_REPEAT_CNT_25M = 25'd5000000;

endpackage

// File: rtl/key_event_decoder.sv
// Turns one debounced active-low key level into single-cycle press, short,
// long, repeat and release pulses plus a held level for the control FSM.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int unsigned          CNT_W      = KEY_CNT_W,
    parameter logic [CNT_W-1:0]     LONG_CNT   = CNT_W'(KEY_LONG_CNT_25M),
    parameter logic [CNT_W-1:0]     REPEAT_CNT = CNT_W'(KEY_REPEAT_CNT_25M),
    parameter logic                 REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic key_held
);

    localparam logic [CNT_W-1:0] LONG_LAST_C   = LONG_CNT - CNT_W'(1);
    localparam logic [CNT_W-1:0] REPEAT_LAST_C = REPEAT_CNT - CNT_W'(1);

    key_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             key_q_r;

    // Edge detect, hold/repeat FSM and registered event outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= KEY_IDLE;
            cnt_r         <= '0;
            key_q_r       <= 1'b1;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            key_held      <= 1'b0;
        end else begin
            key_q_r       <= key_n;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;

            case (state_r)
                KEY_IDLE: begin
                    if (key_q_r && !key_n) begin
                        press_pulse <= 1'b1;
                        state_r     <= KEY_PRESSED;
                        cnt_r       <= '0;
                        key_held    <= 1'b1;
                    end else begin
                        key_held    <= 1'b0;
                    end
                end
                // Release is checked first so it wins over the long threshold
                KEY_PRESSED: begin
                    if (key_n) begin
                        release_pulse <= 1'b1;
                        short_pulse   <= 1'b1;
                        state_r       <= KEY_IDLE;
                        cnt_r         <= '0;
                        key_held      <= 1'b0;
                    end else if (cnt_r == LONG_LAST_C) begin
                        long_pulse    <= 1'b1;
                        state_r       <= KEY_LONG;
                        cnt_r         <= '0;
                        key_held      <= 1'b1;
                    end else begin
                        cnt_r         <= cnt_r + CNT_W'(1);
                        key_held      <= 1'b1;
                    end
                end
                KEY_LONG: begin
                    if (key_n) begin
                        release_pulse <= 1'b1;
                        state_r       <= KEY_IDLE;
                        cnt_r         <= '0;
                        key_held      <= 1'b0;
                    end else if (cnt_r == REPEAT_LAST_C) begin
                        repeat_pulse  <= REPEAT_EN;
                        cnt_r         <= '0;
                        key_held      <= 1'b1;
                    end else begin
                        cnt_r         <= cnt_r + CNT_W'(1);
                        key_held      <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= KEY_IDLE;
                    cnt_r    <= '0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

endmodule
